// File: rtl/stream_demux_pkg.sv
// Shared helpers for stream_demux: select-width derivation and drop-counter ceiling.
package stream_demux_pkg;

  // clog2 with a floor of 1 so a 2-channel demux still gets a 1-bit select.
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic longint unsigned cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry valid/ready holding register for a single demux output channel.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             avail
);

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;

  // Stage p1: a load may land in the same cycle the held entry drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign avail     = ~vld_p1 | out_ready;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;

endmodule

// File: rtl/stream_demux.sv
// Registered valid/ready demultiplexer: routes or broadcasts one input stream to CHANNELS slots.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 8,
  parameter  int CNT_W    = 8,
  localparam int SEL_W    = sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]          drop_count,
  input  logic                      clear_drops
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [CHANNELS-1:0] avail;
  logic [CHANNELS-1:0] route_hit;
  logic [CHANNELS-1:0] load;
  logic                sel_ok;
  logic                accept;
  logic                drop;
  logic [CNT_W-1:0]    drop_cnt_p1;

  assign sel_ok = (int'(in_sel) < CHANNELS);

  always_comb begin
    route_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(in_sel) == i) route_hit[i] = 1'b1;
    end
  end

  // in_ready deliberately excludes in_valid so no valid->ready loop can form upstream.
  always_comb begin
    if (in_bcast)    in_ready = &avail;
    else if (sel_ok) in_ready = |(route_hit & avail);
    else             in_ready = 1'b1;
  end

  assign accept = in_valid & in_ready;
  assign load   = {CHANNELS{accept}} & (in_bcast ? {CHANNELS{1'b1}} : route_hit);
  assign drop   = accept & ~in_bcast & ~sel_ok;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[i]),
      .load_data (in_data),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_data  (out_data[i*WIDTH +: WIDTH]),
      .avail     (avail[i])
    );
  end

  // Stage p1: clear takes priority over a coincident drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           drop_cnt_p1 <= '0;
    else if (clear_drops) drop_cnt_p1 <= '0;
    else if (drop)        drop_cnt_p1 <= sat_inc(drop_cnt_p1);
  end

  assign drop_count = drop_cnt_p1;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux with a per-channel scoreboard (8-ch/8-bit cnt and 6-ch/2-bit cnt instances).
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_bcast, a_clear;
  logic [7:0]  a_data;
  logic [2:0]  a_sel;
  logic [7:0]  a_out_valid, a_out_ready;
  logic [63:0] a_out_data;
  logic [7:0]  a_drop;

  logic        b_valid, b_ready, b_bcast, b_clear;
  logic [7:0]  b_data;
  logic [2:0]  b_sel;
  logic [5:0]  b_out_valid, b_out_ready;
  logic [47:0] b_out_data;
  logic [1:0]  b_drop;

  stream_demux #(.WIDTH(8), .CHANNELS(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_sel(a_sel), .in_bcast(a_bcast),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .drop_count(a_drop), .clear_drops(a_clear)
  );

  stream_demux #(.WIDTH(8), .CHANNELS(6), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bcast),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .drop_count(b_drop), .clear_drops(b_clear)
  );

  int passed = 0;
  int total  = 0;
  logic [7:0] sbq [8][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic bc, input logic [7:0] d);
    a_valid = v; a_sel = s; a_bcast = bc; a_data = d;
    #1;
  endtask

  function automatic logic [7:0] a_ch(input int i);
    return a_out_data[i*8 +: 8];
  endfunction

  // Scoreboard step: compare held outputs, retire handshakes, record accepts, then advance one edge.
  task automatic cycle();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sb_valid%0d", i), a_out_valid[i], q_nonempty(i));
      if (a_out_valid[i] && sbq[i].size() != 0) begin
        chk($sformatf("sb_data%0d", i), a_ch(i), sbq[i][0]);
        if (a_out_ready[i]) void'(sbq[i].pop_front());
      end
    end
    if (a_valid && a_ready) begin
      if (a_bcast) for (int i = 0; i < 8; i++) sbq[i].push_back(a_data);
      else sbq[a_sel].push_back(a_data);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic q_nonempty(input int i);
    return sbq[i].size() != 0;
  endfunction

  initial begin
    rst_n = 1'b0;
    a_valid = 0; a_sel = 0; a_bcast = 0; a_data = 0; a_clear = 0; a_out_ready = 8'hFF;
    b_valid = 0; b_sel = 0; b_bcast = 0; b_data = 0; b_clear = 0; b_out_ready = 6'h3F;
    #2;
    chk("rst_out_valid", a_out_valid, 8'h00);
    chk("rst_out_data_zero", a_out_data == 64'd0, 1);
    chk("rst_drop", a_drop, 0);
    chk("rst_in_ready", a_ready, 1);
    #6 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic route
    drive(1, 3'd5, 0, 8'hA5);
    chk("route_ready", a_ready, 1);
    cycle();
    drive(0, 0, 0, 0);
    chk("route_valid", a_out_valid, 8'h20);
    chk("route_data", a_ch(5), 8'hA5);
    cycle();
    chk("route_drain", a_out_valid, 8'h00);

    // back-pressure on channel 2
    a_out_ready = 8'hFB;
    drive(1, 3'd2, 0, 8'h11);
    chk("bp_first_ready", a_ready, 1);
    cycle();
    drive(1, 3'd2, 0, 8'h22);
    chk("bp_second_blocked", a_ready, 0);
    cycle();
    chk("bp_still_blocked", a_ready, 0);
    chk("bp_hold", a_ch(2), 8'h11);
    cycle();
    a_out_ready = 8'hFF;
    #1;
    chk("bp_release_ready", a_ready, 1);
    cycle();
    drive(0, 0, 0, 0);
    chk("bp_valid", a_out_valid, 8'h04);
    chk("bp_data", a_ch(2), 8'h22);
    cycle();

    // back-to-back stream on channel 3
    for (int d = 1; d <= 10; d++) begin
      drive(1, 3'd3, 0, 8'(d));
      chk("b2b_ready", a_ready, 1);
      if (d > 1) begin
        chk("b2b_valid", a_out_valid, 8'h08);
        chk("b2b_data", a_ch(3), 32'(d - 1));
      end
      cycle();
    end
    drive(0, 0, 0, 0);
    chk("b2b_last", a_ch(3), 8'h0A);
    cycle();

    // broadcast blocked by a full, stalled slot 7
    a_out_ready = 8'h7F;
    drive(1, 3'd7, 0, 8'h99);
    cycle();
    drive(1, 3'd0, 1, 8'h3C);
    chk("bc_blocked", a_ready, 0);
    cycle();
    chk("bc_no_load", a_out_valid, 8'h80);
    a_out_ready = 8'hFF;
    #1;
    chk("bc_release_ready", a_ready, 1);
    cycle();
    drive(0, 0, 0, 0);
    chk("bc_all_valid", a_out_valid, 8'hFF);
    for (int i = 0; i < 8; i++) chk($sformatf("bc_data%0d", i), a_ch(i), 8'h3C);
    cycle();
    chk("bc_drain", a_out_valid, 8'h00);

    // out-of-range drops on the 6-channel instance
    b_valid = 1; b_data = 8'h5A; b_sel = 3'd6;
    #1;
    chk("oor_ready", b_ready, 1);
    cycle();
    b_sel = 3'd7; cycle();
    b_sel = 3'd6; cycle();
    b_valid = 0;
    #1;
    chk("oor_count3", b_drop, 3);
    chk("oor_no_valid", b_out_valid, 0);
    b_valid = 1; b_sel = 3'd7; b_clear = 1;
    cycle();
    b_valid = 0; b_clear = 0;
    #1;
    chk("clear_wins", b_drop, 0);
    b_valid = 1;
    for (int k = 0; k < 5; k++) cycle();
    b_valid = 0;
    #1;
    chk("drop_saturate", b_drop, 3);
    chk("a_drop_untouched", a_drop, 0);

    // asynchronous reset with slots 0 and 4 stalled
    a_out_ready = 8'hEE;
    drive(1, 3'd0, 0, 8'h10);
    cycle();
    drive(1, 3'd4, 0, 8'h40);
    cycle();
    drive(0, 0, 0, 0);
    chk("pre_rst_valid", a_out_valid, 8'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", a_out_valid, 8'h00);
    chk("arst_data_zero", a_out_data == 64'd0, 1);
    chk("arst_drop", b_drop, 0);
    for (int i = 0; i < 8; i++) sbq[i].delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 8'hFF;
    drive(1, 3'd1, 0, 8'h77);
    chk("post_rst_ready", a_ready, 1);
    cycle();
    drive(0, 0, 0, 0);
    chk("post_rst_valid", a_out_valid, 8'h02);
    chk("post_rst_data", a_ch(1), 8'h77);
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered successor to the 8-way bit demultiplexer.
- Routes a WIDTH-bit valid/ready stream to one of CHANNELS output streams selected by in_sel, or to all of them when in_bcast is asserted.
- Each output has a one-entry holding register, so downstream back-pressure on one channel does not corrupt another.
- Out-of-range selects are absorbed and counted.
- Sits between a single producer (e.g. a bus or ALU result stream) and per-destination consumers.

Parameters:
- WIDTH, 8, data width per transfer (>=1).
- CHANNELS, 8, number of output channels (>=2, not necessarily a power of two).
- SEL_W, $clog2(CHANNELS), select width; derived localparam, not overridable.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input transfer offered.
- in_ready  output  1  input transfer accepted this cycle when in_valid & in_ready.
- in_data  input  WIDTH  input payload.
- in_sel  input  SEL_W  target channel index.
- in_bcast  input  1  1 = deliver to every channel; in_sel ignored.
- out_valid  output  CHANNELS  per-channel data valid.
- out_ready  input  CHANNELS  per-channel consumer ready.
- out_data  output  CHANNELS*WIDTH  flattened payloads; channel i occupies bits [i*WIDTH +: WIDTH].
- drop_count  output  CNT_W  saturating count of dropped out-of-range transfers.
- clear_drops  input  1  synchronous clear of drop_count.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, drop_count = 0. in_ready follows its combinational equation from reset values. Reset mid-transfer discards all held data; no partial delivery.
- Slot availability: avail[i] = ~out_valid[i] | out_ready[i]. A slot emptying and refilling in the same cycle is allowed, giving full throughput of 1 transfer/cycle per channel.
- in_ready is combinational from in_sel, in_bcast, out_valid and out_ready. It never depends on in_valid.
  - in_bcast = 1: in_ready = AND of all avail[i].
  - in_bcast = 0 and in_sel < CHANNELS: in_ready = avail[in_sel].
  - in_bcast = 0 and in_sel >= CHANNELS: in_ready = 1; the transfer is dropped.
- Accepted transfer (in_valid & in_ready):
  - Routed: slot in_sel captures in_data and sets out_valid at the next edge. Latency is exactly 1 cycle.
  - Broadcast: every slot captures in_data and sets out_valid at the next edge.
  - Dropped: no slot changes. drop_count increments by 1, saturating at 2^CNT_W-1.
- Output handshake: when out_valid[i] & out_ready[i] and no new capture into slot i, out_valid[i] clears at the next edge.
- Stability rule: while out_valid[i] & ~out_ready[i], out_data[i] must hold.
- Non-targeted slots are unaffected by any input transfer.
- clear_drops:
  - clear_drops & drop event in the same cycle: clear wins; drop_count = 0.
  - clear_drops with no drop event: drop_count = 0 next cycle.
- Input protocol expectation (assertion only, not checked in RTL): in_data, in_sel and in_bcast stay stable while in_valid & ~in_ready.
- No combinational path from in_valid or in_data to any output.
- out_data of an empty slot is don't-care to consumers; the RTL keeps the last value.

Decomposition:
- Package stream_demux_pkg holds the SEL_W derivation function (clog2 with minimum 1) and the drop-counter saturation constant.
- Natural sub-module: demux_slot. It is a one-entry valid/ready register with ports clk, rst_n, load, load_data, out_valid, out_ready, out_data and avail. It is instantiated CHANNELS times in a generate loop.
- The top level contains only the select decode, in_ready logic and drop counter.

Test Plan:
- Basic route: CHANNELS=8, all out_ready=1, send in_sel=5, in_data=0xA5 -> next cycle out_valid=0x20, channel 5 data 0xA5. Following cycle out_valid=0x00.
- Back-pressure: out_ready[2]=0; send two transfers to sel 2 (0x11, 0x22) -> first accepted, in_ready=0 on second. Channel 2 holds 0x11 stable. Raise out_ready[2] -> 0x22 accepted that cycle and appears next cycle.
- Back-to-back, no bubble: out_ready=all 1; stream sel 3 with data 1..10 on consecutive cycles -> in_ready stays 1 and channel 3 emits 1..10 on consecutive cycles.
- Broadcast blocking: out_ready[7]=0 with slot 7 full; in_bcast=1, in_data=0x3C -> in_ready=0 and no slot loads. Release out_ready[7] -> all 8 slots show 0x3C next cycle.
- Out-of-range and counter: CHANNELS=6, send in_sel=6 and 7 (three transfers total) -> in_ready=1, no out_valid change, drop_count=3. Clear_drops with a simultaneous drop -> drop_count=0. With CNT_W=2, send 5 drops -> drop_count=3.
- Async reset mid-operation: slots 0 and 4 full and stalled; pulse rst_n low between clock edges -> out_valid=0 and drop_count=0 immediately, without a clock edge. Normal routing resumes on the first edge after release.
